qvga_cam_fb_writer: RTL and testbench

- Write-side counterpart of the QVGA frame-buffer read path: captures the camera's 8-bit parallel stream (VSYNC/HREF framing, two bytes per RGB565 pixel) and writes 320x240 pixels into the 17-bit-addressed frame buffer.
- Emits a linear write address (y*320+x), a 16-bit pixel word and a write enable.
- Sits between the camera pins and the frame buffer write port; the VGA-side reader consumes the same buffer layout.

---
 rtl/qvga_fb_pkg.sv | 49 ++++
 rtl/cam_byte_pair.sv | 39 +++
 rtl/qvga_cam_fb_writer.sv | 163 ++++++++++++++++
 tb/tb_qvga_cam_fb_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qvga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module : qvga_fb_pkg
// Brief  : Shared frame-buffer geometry, pixel type, capture states, colour bars
// Rev    : 1.0  initial release
// ============================================================================
package qvga_fb_pkg;

    localparam int c_H_PIX      = 320;
    localparam int c_V_PIX      = 240;
    localparam int c_ADDR_W     = 17;
    localparam int c_FB_DEPTH   = 76800;
    localparam int c_BAR_W      = 40;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } cap_state_e;

    localparam logic [15:0] c_BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] c_BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] c_BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] c_BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] c_BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] c_BAR_RED     = 16'hF800;
    localparam logic [15:0] c_BAR_BLUE    = 16'h001F;
    localparam logic [15:0] c_BAR_BLACK   = 16'h0000;

    // Compare chain instead of x/40 keeps the bar lookup divider-free.
    function automatic logic [15:0] bar_color(input logic [15:0] x);
        if      (x < 16'(1 * c_BAR_W)) return c_BAR_WHITE;
        else if (x < 16'(2 * c_BAR_W)) return c_BAR_YELLOW;
        else if (x < 16'(3 * c_BAR_W)) return c_BAR_CYAN;
        else if (x < 16'(4 * c_BAR_W)) return c_BAR_GREEN;
        else if (x < 16'(5 * c_BAR_W)) return c_BAR_MAGENTA;
        else if (x < 16'(6 * c_BAR_W)) return c_BAR_RED;
        else if (x < 16'(7 * c_BAR_W)) return c_BAR_BLUE;
        else                           return c_BAR_BLACK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_byte_pair.sv
`default_nettype none
// ============================================================================
// Module : cam_byte_pair
// Brief  : Pairs camera bytes into 16-bit RGB565 words (high byte first)
// Rev    : 1.0  initial release
// ============================================================================
module cam_byte_pair
    import qvga_fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic       o_valid,
    output rgb565_t    o_pixel
);

    logic       r_phase;
    logic [7:0] r_hi;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_phase <= 1'b0;
            r_hi    <= 8'h00;
        end else if (i_en) begin
            if (!r_phase) begin
                r_hi <= i_data;
            end
            r_phase <= ~r_phase;
        end
    end

    // Strobe is combinational so the writer can register the pixel one edge later.
    assign o_valid = i_en && r_phase;
    assign o_pixel = rgb565_t'({r_hi, i_data});

endmodule
`default_nettype wire

// File: rtl/qvga_cam_fb_writer.sv
`default_nettype none
// ============================================================================
// Module : qvga_cam_fb_writer
// Brief  : Camera VSYNC/HREF byte stream to linear QVGA frame-buffer writes.
//          Optional colour-bar source enabled by QVGA_CAM_TEST_PATTERN_EN.
// Rev    : 1.0  initial release
// ============================================================================
module qvga_cam_fb_writer
    import qvga_fb_pkg::*;
#(
    parameter int H_PIX  = c_H_PIX,
    parameter int V_PIX  = c_V_PIX,
    parameter int ADDR_W = c_ADDR_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        cam_data,
    input  logic              test_en,
    output logic              wclk,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done
);

    localparam int c_X_W = $clog2(H_PIX + 1);
    localparam int c_Y_W = $clog2(V_PIX + 1);

    cap_state_e        r_state;
    cap_state_e        w_state_next;
    logic              r_href_d;
    logic [c_X_W-1:0]  r_x;
    logic [c_Y_W-1:0]  r_y;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic              r_line_px;
    logic              r_frame_px;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    rgb565_t           r_wdata;
    logic              r_frame_done;

    logic              w_active;
    logic              w_line_end;
    logic              w_bp_en;
    logic              w_bp_clear;
    logic              w_bp_valid;
    rgb565_t           w_bp_pixel;
    logic              w_in_frame;
    logic              w_wr;
    rgb565_t           w_pix;
    logic [ADDR_W-1:0] w_next_base;

    assign w_active    = (r_state == ACTIVE);
    assign w_line_end  = w_active && r_href_d && !href;
    assign w_bp_en     = w_active && href && !vsync;
    assign w_bp_clear  = !w_active || vsync || w_line_end;
    assign w_in_frame  = (r_x < c_X_W'(H_PIX)) && (r_y < c_Y_W'(V_PIX));
    assign w_wr        = w_bp_valid && w_in_frame;
    assign w_next_base = r_base + ADDR_W'(H_PIX);

    cam_byte_pair u_byte_pair (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_bp_clear),
        .i_en    (w_bp_en),
        .i_data  (cam_data),
        .o_valid (w_bp_valid),
        .o_pixel (w_bp_pixel)
    );

`ifdef QVGA_CAM_TEST_PATTERN_EN
    assign w_pix = test_en ? rgb565_t'(bar_color(16'(r_x))) : w_bp_pixel;
`else
    logic w_unused_test_en;
    assign w_unused_test_en = test_en;
    assign w_pix            = w_bp_pixel;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // SYNC waits for a full blanking interval so a partial first frame is never captured.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SYNC:    if (vsync)  w_state_next = VBLANK;
            VBLANK:  if (!vsync) w_state_next = ACTIVE;
            ACTIVE:  if (vsync)  w_state_next = VBLANK;
            default: w_state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_href_d     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_base       <= '0;
            r_addr       <= '0;
            r_line_px    <= 1'b0;
            r_frame_px   <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_href_d     <= href;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            if (!w_active || vsync) begin
                if (w_active) begin
                    r_frame_done <= r_frame_px;
                end
                r_x        <= '0;
                r_y        <= '0;
                r_base     <= '0;
                r_addr     <= '0;
                r_line_px  <= 1'b0;
                r_frame_px <= 1'b0;
            end else if (w_line_end) begin
                r_x       <= '0;
                r_line_px <= 1'b0;
                // Only lines that produced pixels consume a row; y saturates at V_PIX.
                if (r_line_px && (r_y < c_Y_W'(V_PIX))) begin
                    r_y    <= r_y + 1'b1;
                    r_base <= w_next_base;
                    r_addr <= w_next_base;
                end else begin
                    r_addr <= r_base;
                end
            end else if (w_bp_valid) begin
                r_line_px <= 1'b1;
                if (r_x < c_X_W'(H_PIX)) begin
                    r_x <= r_x + 1'b1;
                end
                if (w_wr) begin
                    r_we       <= 1'b1;
                    r_waddr    <= r_addr;
                    r_wdata    <= w_pix;
                    r_addr     <= r_addr + 1'b1;
                    r_frame_px <= 1'b1;
                end
            end
        end
    end

    assign wclk       = clk;
    assign we         = r_we;
    assign wAddr      = r_waddr;
    assign wData      = r_wdata;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_qvga_cam_fb_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_qvga_cam_fb_writer
// Brief  : Directed self-checking bench for qvga_cam_fb_writer
// Rev    : 1.0  initial release
// ============================================================================
module tb_qvga_cam_fb_writer;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        href;
    logic [7:0]  cam_data;
    logic        test_en;
    logic        wclk;
    logic        we;
    logic [16:0] wAddr;
    logic [15:0] wData;
    logic        frame_done;

    int n_checks;
    int n_fail;

    int  wr_cnt;
    int  max_addr;
    int  min_addr;
    int  last_addr;
    int  fd_cnt;
    int  fd_long;
    int  we_long;
    bit  we_prev;
    bit  fd_prev;
    logic [15:0] mem [int];

    qvga_cam_fb_writer u_dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .href       (href),
        .cam_data   (cam_data),
        .test_en    (test_en),
        .wclk       (wclk),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            mem[int'(wAddr)] = wData;
            wr_cnt    = wr_cnt + 1;
            last_addr = int'(wAddr);
            if (int'(wAddr) > max_addr) max_addr = int'(wAddr);
            if (int'(wAddr) < min_addr) min_addr = int'(wAddr);
        end
        if (we && we_prev) we_long = we_long + 1;
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (frame_done && fd_prev) fd_long = fd_long + 1;
        we_prev = we;
        fd_prev = frame_done;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_at(input int a);
        if (mem.exists(a)) return {16'h0000, mem[a]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic clear_mon();
        mem.delete();
        wr_cnt    = 0;
        max_addr  = 0;
        min_addr  = 32'h7FFF_FFFF;
        last_addr = -1;
        fd_cnt    = 0;
        fd_long   = 0;
        we_long   = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        href     = 1'b1;
        cam_data = b;
        tick();
    endtask

    task automatic idle(input int n);
        href = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_line(input int npix, input bit odd);
        logic [7:0] kb;
        for (int k = 0; k < npix; k++) begin
            kb = 8'(k);
            send_byte(kb);
            send_byte(~kb);
        end
        if (odd) send_byte(8'hAA);
        idle(2);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [7:0] kb;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        vsync    = 1'b0;
        href     = 1'b0;
        cam_data = 8'h00;
        test_en  = 1'b0;
        we_prev  = 1'b0;
        fd_prev  = 1'b0;
        clear_mon();
        repeat (3) tick();
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_waddr", {15'b0, wAddr}, 32'd0);
        check("rst_wdata", {16'b0, wData}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        reset = 1'b0;
        tick();

        // Bytes before the first vsync are not captured.
        send_line(4, 1'b0);
        check("sync_ignore_wr", wr_cnt, 32'd0);

        vsync_pulse();
        clear_mon();
        send_byte(8'h12);
        check("lat_first_byte_we", {31'b0, we}, 32'd0);
        send_byte(8'h34);
        check("lat_we", {31'b0, we}, 32'd1);
        check("lat_wdata", {16'b0, wData}, 32'h1234);
        check("lat_waddr", {15'b0, wAddr}, 32'd0);
        for (int k = 1; k < 320; k++) begin
            kb = 8'(k);
            send_byte(kb);
            if (k == 1) check("we_one_cycle", {31'b0, we}, 32'd0);
            send_byte(~kb);
        end
        idle(2);
        check("line_wr_cnt", wr_cnt, 32'd320);
        check("line_min_addr", min_addr, 32'd0);
        check("line_max_addr", max_addr, 32'd319);
        check("line_distinct", mem.num(), 32'd320);
        check("line_px5", mem_at(5), 32'h05FA);
        check("line_px319", mem_at(319), 32'h3FC0);
        check("line_we_long", we_long, 32'd0);
        check("line_no_fd_yet", fd_cnt, 32'd0);
        vsync = 1'b1;
        tick();
        check("fd_pulse", {31'b0, frame_done}, 32'd1);
        tick();
        check("fd_one_cycle", {31'b0, frame_done}, 32'd0);
        idle(2);
        vsync = 1'b0;
        idle(2);

        // Long line with dangling odd byte.
        clear_mon();
        send_line(330, 1'b1);
        check("clip_x_wr_cnt", wr_cnt, 32'd320);
        check("clip_x_max", max_addr, 32'd319);
        send_line(2, 1'b0);
        check("odd_drop_px0", mem_at(320), 32'h00FF);
        check("odd_drop_px1", mem_at(321), 32'h01FE);
        check("odd_drop_wr_cnt", wr_cnt, 32'd322);
        vsync_pulse();

        // 250 lines: 239 one-pixel lines, one full line 239, ten clipped lines.
        clear_mon();
        for (int l = 0; l < 250; l++) begin
            send_line((l == 239) ? 320 : 1, 1'b0);
        end
        check("frame_wr_cnt", wr_cnt, 32'd559);
        check("frame_max_addr", max_addr, 32'd76799);
        check("frame_last_addr", last_addr, 32'd76799);
        check("frame_l238_base", mem_at(76160), 32'h00FF);
        check("frame_l239_base", mem_at(76480), 32'h00FF);
        check("frame_last_px", mem_at(76799), 32'h3FC0);
        check("frame_fd_early", fd_cnt, 32'd0);
        vsync = 1'b1;
        idle(3);
        check("frame_fd_cnt", fd_cnt, 32'd1);
        check("frame_fd_long", fd_long, 32'd0);
        vsync = 1'b0;
        idle(2);

        // Empty frame: no frame_done.
        clear_mon();
        vsync_pulse();
        check("empty_frame_fd", fd_cnt, 32'd0);

        // Reset mid-line at pixel 100.
        clear_mon();
        for (int k = 0; k < 100; k++) begin
            kb = 8'(k);
            send_byte(kb);
            send_byte(~kb);
        end
        send_byte(8'h64);
        href     = 1'b1;
        cam_data = 8'h9B;
        reset    = 1'b1;
        tick();
        check("midrst_we", {31'b0, we}, 32'd0);
        reset = 1'b0;
        for (int k = 101; k < 120; k++) begin
            kb = 8'(k);
            send_byte(kb);
            send_byte(~kb);
        end
        vsync = 1'b1;
        for (int k = 0; k < 4; k++) send_byte(8'h55);
        idle(2);
        vsync = 1'b0;
        idle(2);
        check("midrst_wr_cnt", wr_cnt, 32'd100);
        check("midrst_no_px100", mem_at(100), 32'hFFFF_FFFF);
        check("midrst_no_fd", fd_cnt, 32'd0);
        clear_mon();
        send_line(3, 1'b0);
        check("midrst_restart_wr", wr_cnt, 32'd3);
        check("midrst_restart_min", min_addr, 32'd0);
        check("midrst_restart_px2", mem_at(2), 32'h02FD);

        // Test pattern selection.
        vsync_pulse();
        clear_mon();
        test_en = 1'b1;
        send_line(320, 1'b0);
        test_en = 1'b0;
`ifdef QVGA_CAM_TEST_PATTERN_EN
        check("tp_x0", mem_at(0), 32'hFFFF);
        check("tp_x45", mem_at(45), 32'hFFE0);
        check("tp_x120", mem_at(120), 32'h07E0);
        check("tp_x300", mem_at(300), 32'h0000);
`else
        check("tp_off_x0", mem_at(0), 32'h00FF);
        check("tp_off_x45", mem_at(45), 32'h2DD2);
        check("tp_off_x300", mem_at(300), 32'h2CD3);
`endif
        check("tp_wr_cnt", wr_cnt, 32'd320);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
